pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_det.sv | 25 ++
 rtl/pipe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: the control-state
// encoding plus the default register-address and counter widths.
package pipe_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int CNT_W      = 8;
    localparam int PERF_W     = 16;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } pipe_state_e;

endpackage

// File: rtl/hazard_det.sv
// Load-use hazard detector: flags an ID-stage instruction that reads the
// register a load currently in EX is about to write.
module hazard_det
    import pipe_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_id_rs1,
    input  logic [ADDR_W-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic              i_ex_valid,
    input  logic              i_ex_is_load,
    input  logic [ADDR_W-1:0] i_ex_write_addr,
    output logic              o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_ex_write_addr);
    assign w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_ex_write_addr);
    assign o_hazard    = i_ex_valid && i_ex_is_load && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/halt controller. Handles load-use bubbles, data-memory
// wait states with a timeout, and a halt that drains the back end before
// stopping the core. Optional stall-cycle performance counter is built
// when the PIPE_PERF_EN macro is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int TIMEOUT   = 15,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_write_addr,
    input  logic              id_halt,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              if_freeze,
    output logic              id_freeze,
    output logic              freeze,
    output logic              ld_inst_halt,
    output logic              core_halted,
    output logic              mem_err
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_C   = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    pipe_state_e      r_state;
    pipe_state_e      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_mem_err;
    logic             w_err_next;

    logic w_hazard;
    logic w_mem_stall;
    logic w_if_freeze;
    logic w_id_freeze;
    logic w_freeze;
    logic w_ld_inst_halt;
    logic w_core_halted;

    hazard_det #(
        .ADDR_W(ADDR_W)
    ) u_hazard_det (
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_rs1_used   (id_rs1_used),
        .i_id_rs2_used   (id_rs2_used),
        .i_ex_valid      (ex_valid),
        .i_ex_is_load    (ex_is_load),
        .i_ex_write_addr (ex_write_addr),
        .o_hazard        (w_hazard)
    );

    // A request answered in the same cycle never counts as a stall.
    assign w_mem_stall = mem_req && !mem_ready;

    // State, shared wait/drain counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_mem_err <= w_err_next;
        end
    end

    // Next state and freeze outputs; memory stall beats hazard beats halt.
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_err_next     = r_mem_err;
        w_if_freeze    = 1'b0;
        w_id_freeze    = 1'b0;
        w_freeze       = 1'b0;
        w_ld_inst_halt = 1'b0;
        w_core_halted  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_if_freeze = 1'b1;
                    w_id_freeze = 1'b1;
                    w_freeze    = 1'b1;
                    w_next      = ST_MEM_WAIT;
                    w_cnt_next  = ONE_C;
                end else if (w_hazard) begin
                    w_if_freeze    = 1'b1;
                    w_id_freeze    = 1'b1;
                    w_ld_inst_halt = 1'b1;
                end else if (id_halt) begin
                    w_if_freeze = 1'b1;
                    w_id_freeze = 1'b1;
                    w_cnt_next  = DRAIN_C;
                    w_next      = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_next     = ST_RUN;
                    w_cnt_next = '0;
                end else begin
                    w_if_freeze = 1'b1;
                    w_id_freeze = 1'b1;
                    w_freeze    = 1'b1;
                    if (r_cnt >= TIMEOUT_C) begin
                        w_next     = ST_HALTED;
                        w_err_next = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + ONE_C;
                    end
                end
            end
            ST_DRAIN: begin
                w_if_freeze = 1'b1;
                w_id_freeze = 1'b1;
                if (w_mem_stall) begin
                    w_freeze = 1'b1;
                end else if (r_cnt <= ONE_C) begin
                    w_next     = ST_HALTED;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - ONE_C;
                end
            end
            ST_HALTED: begin
                w_if_freeze   = 1'b1;
                w_id_freeze   = 1'b1;
                w_freeze      = 1'b1;
                w_core_halted = 1'b1;
            end
            default: begin
                w_next     = ST_RUN;
                w_cnt_next = '0;
            end
        endcase
    end

    assign if_freeze    = rst_n && w_if_freeze;
    assign id_freeze    = rst_n && w_id_freeze;
    assign freeze       = rst_n && w_freeze;
    assign ld_inst_halt = rst_n && w_ld_inst_halt;
    assign core_halted  = rst_n && w_core_halted;
    assign mem_err      = rst_n && r_mem_err;

`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;

    // Count fetch-frozen cycles while the core is still live, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_if_freeze && (r_state != ST_HALTED) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int TIMEOUT   = 15;
    localparam int DRAIN_CYC = 3;

    logic       clk;
    logic       rst_n;
    logic [5:0] id_rs1;
    logic [5:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       ex_valid;
    logic       ex_is_load;
    logic [5:0] ex_write_addr;
    logic       id_halt;
    logic       mem_req;
    logic       mem_ready;
    logic       if_freeze;
    logic       id_freeze;
    logic       freeze;
    logic       ld_inst_halt;
    logic       core_halted;
    logic       mem_err;
`ifdef PIPE_PERF_EN
    logic [15:0] stall_cycles;
`endif

    logic [5:0] got;
    int compareCount = 0;
    int failCount    = 0;

    // Behavioural model state.
    bit mWaiting;
    int mWaited;
    bit mDraining;
    int mDrainLeft;
    bit mStopped;
    bit mErr;
    int mStalls;

    pipe_ctrl #(
        .ADDR_W   (6),
        .TIMEOUT  (TIMEOUT),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_write_addr(ex_write_addr),
        .id_halt      (id_halt),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .if_freeze    (if_freeze),
        .id_freeze    (id_freeze),
        .freeze       (freeze),
        .ld_inst_halt (ld_inst_halt),
        .core_halted  (core_halted),
        .mem_err      (mem_err)
`ifdef PIPE_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    assign got = {if_freeze, id_freeze, freeze, ld_inst_halt, core_halted, mem_err};

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever wanders off.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {if,id,freeze,ld_halt,halted,err} for the current inputs.
    function automatic logic [5:0] modelOutputs();
        logic hz;
        logic stall;
        hz = ex_valid && ex_is_load &&
             ((id_rs1_used && id_rs1 == ex_write_addr) ||
              (id_rs2_used && id_rs2 == ex_write_addr));
        stall = mem_req && !mem_ready;
        if (!rst_n) return 6'b000000;
        if (mStopped) return {5'b11101, mErr};
        if (mWaiting) return mem_ready ? {5'b00000, mErr} : {5'b11100, mErr};
        if (mDraining) return {2'b11, stall, 2'b00, mErr};
        if (stall) return {5'b11100, mErr};
        if (hz) return {5'b11010, mErr};
        if (id_halt) return {5'b11000, mErr};
        return {5'b00000, mErr};
    endfunction

    // Model advances on each clock edge, wiped by reset.
    always @(posedge clk or negedge rst_n) begin
        logic [5:0] e;
        if (!rst_n) begin
            mWaiting = 0; mWaited = 0; mDraining = 0; mDrainLeft = 0;
            mStopped = 0; mErr = 0; mStalls = 0;
        end else begin
            e = modelOutputs();
            if (e[5] && !mStopped && mStalls < 65535) mStalls++;
            if (mStopped) begin
            end else if (mWaiting) begin
                if (mem_ready) mWaiting = 0;
                else if (mWaited == TIMEOUT) begin
                    mWaiting = 0; mStopped = 1; mErr = 1;
                end else mWaited++;
            end else if (mDraining) begin
                if (!(mem_req && !mem_ready)) begin
                    mDrainLeft--;
                    if (mDrainLeft == 0) begin
                        mDraining = 0; mStopped = 1;
                    end
                end
            end else if (mem_req && !mem_ready) begin
                mWaiting = 1; mWaited = 1;
            end else if (e[2]) begin
            end else if (id_halt) begin
                mDraining = 1; mDrainLeft = DRAIN_CYC;
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] rs1, input logic [5:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic ev, input logic ld, input logic [5:0] wa,
                                 input logic halt, input logic req, input logic rdy);
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_valid = ev; ex_is_load = ld; ex_write_addr = wa;
        id_halt = halt; mem_req = req; mem_ready = rdy;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_write_addr = '0;
        id_halt = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clk);
        rst_n = 1'b0;
        id_rs1 = 6'd5; id_rs1_used = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1;
        ex_write_addr = 6'd5; mem_req = 1'b1; id_halt = 1'b1;
        #2;
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_outputs got=%b want=000000", got);
        end
        doReset();
        applyIdle();
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_release got=%b want=000000", got);
        end
    endtask

    task automatic test_load_use();
        doReset();
        applyStimulus(6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b110100) begin
            failCount++;
            $display("[TB] FAIL load_use_rs1 got=%b want=110100", got);
        end
        applyIdle();
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL load_use_after got=%b want=000000", got);
        end
        applyStimulus(6'd5, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL load_use_unused got=%b want=000000", got);
        end
        applyStimulus(6'd1, 6'd9, 1'b1, 1'b1, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b110100) begin
            failCount++;
            $display("[TB] FAIL load_use_rs2 got=%b want=110100", got);
        end
        applyStimulus(6'd9, 6'd9, 1'b1, 1'b1, 1'b1, 1'b0, 6'd9, 1'b0, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL load_use_not_load got=%b want=000000", got);
        end
    endtask

    task automatic test_mem_wait();
        int highCycles;
        doReset();
        highCycles = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (got === 6'b111000) highCycles++;
        end
        compareCount++;
        if (highCycles != 4) begin
            failCount++;
            $display("[TB] FAIL mem_wait_freeze_cycles got=%0d want=4", highCycles);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL mem_wait_ready_cycle got=%b want=000000", got);
        end
        applyStimulus(6'd3, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b110100) begin
            failCount++;
            $display("[TB] FAIL mem_wait_back_in_run got=%b want=110100", got);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL mem_same_cycle_ready got=%b want=000000", got);
        end
        applyStimulus(6'd3, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 1'b0);
        compareCount++;
        if (got !== 6'b111000) begin
            failCount++;
            $display("[TB] FAIL mem_over_hazard got=%b want=111000", got);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyIdle();
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL mem_priority_exit got=%b want=000000", got);
        end
    endtask

    task automatic test_timeout();
        int highCycles;
        doReset();
        highCycles = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (got === 6'b111000) highCycles++;
        end
        compareCount++;
        if (highCycles != TIMEOUT + 1) begin
            failCount++;
            $display("[TB] FAIL timeout_wait_cycles got=%0d want=%0d", highCycles, TIMEOUT + 1);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        compareCount++;
        if (got !== 6'b111011) begin
            failCount++;
            $display("[TB] FAIL timeout_halted got=%b want=111011", got);
        end
        repeat (3) applyIdle();
        compareCount++;
        if (got !== 6'b111011) begin
            failCount++;
            $display("[TB] FAIL timeout_sticky got=%b want=111011", got);
        end
    endtask

    task automatic test_halt_drain();
        int drainCycles;
        doReset();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b110000) begin
            failCount++;
            $display("[TB] FAIL halt_first_cycle got=%b want=110000", got);
        end
        drainCycles = 0;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            applyIdle();
            if (got === 6'b110000) drainCycles++;
        end
        compareCount++;
        if (drainCycles != DRAIN_CYC) begin
            failCount++;
            $display("[TB] FAIL halt_drain_cycles got=%0d want=%0d", drainCycles, DRAIN_CYC);
        end
        applyIdle();
        compareCount++;
        if (got !== 6'b111010) begin
            failCount++;
            $display("[TB] FAIL halt_core_halted got=%b want=111010", got);
        end

        // Halt that collides with a hazard is deferred one cycle.
        doReset();
        applyStimulus(6'd7, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
        compareCount++;
        if (got !== 6'b110100) begin
            failCount++;
            $display("[TB] FAIL halt_vs_hazard got=%b want=110100", got);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (DRAIN_CYC) applyIdle();
        compareCount++;
        if (got !== 6'b110000) begin
            failCount++;
            $display("[TB] FAIL halt_deferred_drain got=%b want=110000", got);
        end
        applyIdle();
        compareCount++;
        if (got !== 6'b111010) begin
            failCount++;
            $display("[TB] FAIL halt_deferred_halted got=%b want=111010", got);
        end

        // Memory stall inside drain freezes EX and pauses the countdown.
        doReset();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        compareCount++;
        if (got !== 6'b111000) begin
            failCount++;
            $display("[TB] FAIL drain_mem_stall got=%b want=111000", got);
        end
        repeat (DRAIN_CYC) applyIdle();
        compareCount++;
        if (got !== 6'b110000) begin
            failCount++;
            $display("[TB] FAIL drain_paused_count got=%b want=110000", got);
        end
        applyIdle();
        compareCount++;
        if (got !== 6'b111010) begin
            failCount++;
            $display("[TB] FAIL drain_paused_halted got=%b want=111010", got);
        end
    endtask

    task automatic test_reset_mid_op();
        doReset();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_mid_wait got=%b want=000000", got);
        end
`ifdef PIPE_PERF_EN
        compareCount++;
        if (stall_cycles !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_stall_count got=%0d want=0", stall_cycles);
        end
`endif
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyIdle();
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_mid_wait_after got=%b want=000000", got);
        end

        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyIdle();
        #1;
        rst_n = 1'b0;
        #1;
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_mid_drain got=%b want=000000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DRAIN_CYC + 1) applyIdle();
        compareCount++;
        if (got !== 6'b000000) begin
            failCount++;
            $display("[TB] FAIL reset_mid_drain_after got=%b want=000000", got);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        int stoppedFor;
        doReset();
        stoppedFor = 0;
        for (int i = 0; i < 600; i++) begin
            applyStimulus(6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 3)),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) != 0));
            exp = modelOutputs();
            compareCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL random_outputs cycle=%0d got=%b want=%b", i, got, exp);
            end
`ifdef PIPE_PERF_EN
            compareCount++;
            if (stall_cycles !== 16'(mStalls)) begin
                failCount++;
                $display("[TB] FAIL random_stall_count cycle=%0d got=%0d want=%0d", i, stall_cycles, mStalls);
            end
`endif
            stoppedFor = mStopped ? stoppedFor + 1 : 0;
            if (stoppedFor > 2) begin
                doReset();
                stoppedFor = 0;
            end
        end
    endtask

    // Scenario sequence and final tally.
    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_write_addr = '0;
        id_halt = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
